dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 128-word data memory.
- Requester m0 is the core load/store path; m1 is the debug/DMA loader.
- Grants one access at a time with round-robin fairness and drives the memory's MemRead/MemWrite/addr/write_data.
- Captures the memory's read data and returns it to the winning requester through a req/ready handshake.
- Misaligned accesses are rejected with an error response and never reach the memory.

Parameters:
ADDR_W, 9, byte address width; memory holds 2^(ADDR_W-2) words.
DATA_W, 32, data word width.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
m0_req  in  1  m0 access request; held with fields stable until m0_ready
m0_we  in  1  1 = write, 0 = read
m0_addr  in  ADDR_W  byte address
m0_wdata  in  DATA_W  write data
m0_ready  out  1  one-cycle completion pulse
m0_rdata  out  DATA_W  read data; valid while m0_ready=1 for a read
m0_err  out  1  with m0_ready: access rejected as misaligned
m1_req, m1_we, m1_addr, m1_wdata, m1_ready, m1_rdata, m1_err  same as m0
mem_read  out  1  to memory MemRead
mem_write  out  1  to memory MemWrite
mem_addr  out  ADDR_W  to memory addr
mem_wdata  out  DATA_W  to memory write_data
mem_rdata  in  DATA_W  from memory read_data (combinational)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_grant=1 (so m0 wins first), all outputs 0, latched request registers 0. Reset mid-access aborts it immediately; mem_read and mem_write drop in the same instant. No response is issued for an aborted access.
- State machine: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that requester.
  - Both req: grant the requester that is not last_grant.
  - On grant, latch winner id, we, addr, wdata; set err_q = (addr[1:0] != 0); go to ACCESS.
- ACCESS (one cycle):
  - mem_addr and mem_wdata driven from the latched registers.
  - If err_q=0: mem_write = we_q, mem_read = !we_q.
  - If err_q=1: both strobes 0.
  - At the clock edge, rdata_q <= mem_rdata when this is a read with err_q=0; otherwise rdata_q <= 0. Go to RESP.
- RESP (one cycle):
  - Winner's ready=1; winner's rdata=rdata_q; winner's err=err_q.
  - Loser's ready, rdata and err stay 0.
  - last_grant <= winner. Go to IDLE.
- Outside RESP: all m*_ready, m*_err and m*_rdata are 0. mem_read and mem_write are 0 outside ACCESS. mem_addr and mem_wdata hold their last latched values.
- Latency: request seen in IDLE at edge N; strobes high during cycle N+1; ready during cycle N+2. Earliest next grant is at edge N+3, giving a throughput of 1 access per 3 cycles.
- A requester must keep req high until ready. Deasserting req before ready is a protocol violation; the latched access still completes and still produces its ready pulse.
- Re-request: a requester may hold req high through ready to issue back-to-back accesses. Round-robin then alternates while both requesters are active. A lone requester is granted every 3 cycles.
- Addressing: full ADDR_W byte address passed through unchanged; the memory ignores bits [1:0]. No bounds check is needed because ADDR_W exactly covers the memory.

Test Plan:
- Reset, then m0 write addr=0x010 data=0xDEADBEEF -> mem_write=1 for exactly 1 cycle with mem_addr=0x010; m0_ready pulses 2 cycles after grant; m0_err=0.
- m0 read addr=0x010 after that write -> mem_read=1 for 1 cycle; m0_rdata=0xDEADBEEF during the m0_ready pulse; m1 outputs stay 0.
- m0 and m1 both hold req continuously with distinct addresses -> grants ordered m0, m1, m0, m1; each ready pulse is 3 cycles apart; no starvation.
- m1 write addr=0x013 -> mem_write and mem_read stay 0 throughout; m1_ready=1 with m1_err=1 and m1_rdata=0; memory word 4 is unchanged on a later read.
- rst_n driven low during ACCESS of a write -> mem_write falls immediately and no ready pulse occurs; after release, state=IDLE and m0 wins the first simultaneous request.
- Write last word addr=0x1FC data=0x12345678, then read it back -> m*_rdata=0x12345678, confirming the top of the address range.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Request/response and memory-side bus of the data-memory arbiter.
// slave = arbiter side, master = requesters plus memory.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);
   logic              m0_req;
   logic              m0_we;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_ready;
   logic [DATA_W-1:0] m0_rdata;
   logic              m0_err;

   logic              m1_req;
   logic              m1_we;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_ready;
   logic [DATA_W-1:0] m1_rdata;
   logic              m1_err;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_ready, m0_rdata, m0_err,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m1_ready, m1_rdata, m1_err,
      output mem_read, mem_write,
      output mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_ready, m0_rdata, m0_err,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m1_ready, m1_rdata, m1_err,
      input  mem_read, mem_write,
      input  mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-requester arbiter/sequencer for the data memory.
// IDLE -> ACCESS -> RESP; misaligned accesses never strobe the memory.
module dmem_arbiter #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   dmem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t            state;
   logic              last_grant;
   logic              win_q;
   logic              we_q;
   logic              err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              any_req;
   logic              win;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_err;
   logic [DATA_W-1:0] rd;

   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

   assign any_req = bus.m0_req | bus.m1_req;

   // On contention the requester that did not win last time goes next.
   always_comb begin
      win = 1'b0;
      unique case (1'b1)
         bus.m0_req & bus.m1_req:  win = ~last_grant;
         ~bus.m0_req & bus.m1_req: win = 1'b1;
         default:                  win = 1'b0;
      endcase
   end

   assign sel_we    = win ? bus.m1_we    : bus.m0_we;
   assign sel_addr  = win ? bus.m1_addr  : bus.m0_addr;
   assign sel_wdata = win ? bus.m1_wdata : bus.m0_wdata;
   assign sel_err   = |sel_addr[1:0];

   assign rd = (!we_q && !err_q) ? bus.mem_rdata : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         win_q         <= 1'b0;
         we_q          <= 1'b0;
         err_q         <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         bus.mem_read  <= 1'b0;
         bus.mem_write <= 1'b0;
         bus.m0_ready  <= 1'b0;
         bus.m0_err    <= 1'b0;
         bus.m0_rdata  <= '0;
         bus.m1_ready  <= 1'b0;
         bus.m1_err    <= 1'b0;
         bus.m1_rdata  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  win_q         <= win;
                  we_q          <= sel_we;
                  addr_q        <= sel_addr;
                  wdata_q       <= sel_wdata;
                  err_q         <= sel_err;
                  bus.mem_write <= sel_we & ~sel_err;
                  bus.mem_read  <= ~sel_we & ~sel_err;
                  state         <= ACCESS;
               end
            end
            ACCESS: begin
               bus.mem_write <= 1'b0;
               bus.mem_read  <= 1'b0;
               bus.m0_ready  <= ~win_q;
               bus.m1_ready  <= win_q;
               bus.m0_err    <= ~win_q & err_q;
               bus.m1_err    <= win_q & err_q;
               bus.m0_rdata  <= win_q ? '0 : rd;
               bus.m1_rdata  <= win_q ? rd : '0;
               state         <= RESP;
            end
            RESP: begin
               bus.m0_ready <= 1'b0;
               bus.m1_ready <= 1'b0;
               bus.m0_err   <= 1'b0;
               bus.m1_err   <= 1'b0;
               bus.m0_rdata <= '0;
               bus.m1_rdata <= '0;
               last_grant   <= win_q;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 128-word memory model.
// Inputs driven and outputs sampled on the falling edge.
module tb_dmem_arbiter;
   logic clk;
   logic rst_n;
   int   vecs;
   int   errs;

   dmem_arbiter_if #(.ADDR_W(9), .DATA_W(32)) bus ();

   dmem_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [31:0] mem [128] = '{default: 32'h0};

   assign bus.mem_rdata = mem[bus.mem_addr[8:2]];

   always @(posedge clk)
      if (bus.mem_write)
         mem[bus.mem_addr[8:2]] <= bus.mem_wdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit who, input bit req,
                        input bit we, input logic [8:0] a,
                        input logic [31:0] wd);
      if (who) begin
         bus.m1_req = req; bus.m1_we = we;
         bus.m1_addr = a;  bus.m1_wdata = wd;
      end else begin
         bus.m0_req = req; bus.m0_we = we;
         bus.m0_addr = a;  bus.m0_wdata = wd;
      end
   endtask

   // One access from a lone requester, starting at a falling edge.
   task automatic access(input string tag, input bit who,
                         input bit we, input logic [8:0] a,
                         input logic [31:0] wd,
                         input logic [31:0] exp_rd,
                         input bit exp_err);
      int nwr, nrd, nrdy, oth, rc;
      logic [8:0]  s_addr;
      logic [31:0] s_wd, g_rd;
      logic        g_err, rdy;
      nwr = 0; nrd = 0; nrdy = 0; oth = 0; rc = 0;
      s_addr = '0; s_wd = '0; g_rd = '0; g_err = 1'b0;
      drive(who, 1'b1, we, a, wd);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (bus.mem_write || bus.mem_read) begin
            s_addr = bus.mem_addr;
            s_wd   = bus.mem_wdata;
         end
         nwr += int'(bus.mem_write);
         nrd += int'(bus.mem_read);
         rdy = who ? bus.m1_ready : bus.m0_ready;
         oth += int'(who ? bus.m0_ready : bus.m1_ready);
         oth += int'(who ? bus.m0_err : bus.m1_err);
         oth += int'(who ? |bus.m0_rdata : |bus.m1_rdata);
         if (rdy) begin
            nrdy++;
            rc    = c;
            g_rd  = who ? bus.m1_rdata : bus.m0_rdata;
            g_err = who ? bus.m1_err : bus.m0_err;
            drive(who, 1'b0, we, a, wd);
         end
      end
      chk({tag, ".rdy_cyc"}, rc, 2);
      chk({tag, ".rdy_cnt"}, nrdy, 1);
      chk({tag, ".wr_cnt"}, nwr, (we && !exp_err) ? 1 : 0);
      chk({tag, ".rd_cnt"}, nrd, (!we && !exp_err) ? 1 : 0);
      if (!exp_err) begin
         chk({tag, ".addr"}, {23'h0, s_addr}, {23'h0, a});
         if (we) chk({tag, ".wdata"}, s_wd, wd);
      end
      chk({tag, ".rdata"}, g_rd, exp_rd);
      chk({tag, ".err"}, {31'h0, g_err}, {31'h0, exp_err});
      chk({tag, ".other"}, oth, 0);
   endtask

   initial begin
      vecs  = 0;
      errs  = 0;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 9'h0, 32'h0);
      #12;
      chk("rst.mem_rd", bus.mem_read, 0);
      chk("rst.mem_wr", bus.mem_write, 0);
      chk("rst.mem_addr", {23'h0, bus.mem_addr}, 0);
      chk("rst.m0_rdy", bus.m0_ready, 0);
      chk("rst.m1_rdy", bus.m1_ready, 0);
      chk("rst.m0_rdata", bus.m0_rdata, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      access("m0_wr", 1'b0, 1'b1, 9'h010, 32'hDEADBEEF,
             32'h0, 1'b0);
      access("m0_rd", 1'b0, 1'b0, 9'h010, 32'h0,
             32'hDEADBEEF, 1'b0);
      access("m1_mis", 1'b1, 1'b1, 9'h013, 32'hCAFEF00D,
             32'h0, 1'b1);

      // Both requesters hold req: grants must alternate m0, m1, ...
      drive(1'b0, 1'b1, 1'b0, 9'h010, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 9'h024, 32'h0);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         chk($sformatf("rr.m0_rdy@%0d", c), bus.m0_ready,
             (c == 2 || c == 8) ? 1 : 0);
         chk($sformatf("rr.m1_rdy@%0d", c), bus.m1_ready,
             (c == 5 || c == 11) ? 1 : 0);
         if (c == 1 || c == 7)
            chk("rr.addr_m0", {23'h0, bus.mem_addr}, 32'h010);
         if (c == 4)
            chk("rr.addr_m1", {23'h0, bus.mem_addr}, 32'h024);
         if (c == 2)
            chk("rr.m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
      end
      drive(1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 9'h0, 32'h0);
      @(negedge clk);

      access("w4_keep", 1'b0, 1'b0, 9'h010, 32'h0,
             32'hDEADBEEF, 1'b0);
      access("top_wr", 1'b1, 1'b1, 9'h1FC, 32'h12345678,
             32'h0, 1'b0);
      access("top_rd", 1'b0, 1'b0, 9'h1FC, 32'h0,
             32'h12345678, 1'b0);

      // Async reset in the middle of a write's strobe cycle.
      drive(1'b0, 1'b1, 1'b1, 9'h040, 32'hAAAA5555);
      @(negedge clk);
      chk("abort.wr_before", bus.mem_write, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort.wr_drop", bus.mem_write, 0);
      drive(1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk($sformatf("abort.no_rdy@%0d", c),
             {31'h0, bus.m0_ready | bus.m1_ready}, 0);
      end

      drive(1'b0, 1'b1, 1'b0, 9'h040, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 9'h010, 32'h0);
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         if (c == 1)
            chk("post.addr", {23'h0, bus.mem_addr}, 32'h040);
      end
      chk("post.m0_rdy", bus.m0_ready, 1);
      chk("post.m1_rdy", bus.m1_ready, 0);
      chk("post.m0_rdata", bus.m0_rdata, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 9'h0, 32'h0);
      @(negedge clk);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==",
               vecs, errs);
      $finish;
   end
endmodule
